count_accum: RTL and testbench

Parametrised multi-op counter-table engine for the PCIe/AXI statistics path: holds DEPTH counters of WIDTH bits in a dual-port RAM and applies one operation per clock (add, set, read, read-and-clear) to the indexed counter, returning the result three cycles later. It extends the single-mode accumulate-only updater with a wider increment port, saturating/wrapping overflow, readout ops, an overflow flag and a post-reset clear sweep with a ready indication. It sits between the event decoders and the host-visible stats drain.

---
 rtl/count_accum.sv | 236 +++++++++++++++++++++++
 tb/tb_count_accum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_accum.sv
// Counter-table engine: DEPTH counters in a dual-port RAM, one ADD/SET/READ/RDCLR per clock,
// result three cycles after acceptance, with store forwarding and a post-reset clear sweep.
module count_accum #(
   parameter int DEPTH     = 512,
   parameter int WIDTH     = 32,
   parameter int INC_WIDTH = 16,
   parameter int SATURATE  = 1,
   localparam int ABIT     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic [1:0]           i_op,
   input  logic [ABIT-1:0]      i_index,
   input  logic [INC_WIDTH-1:0] i_inc,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [ABIT-1:0]      o_index,
   output logic [WIDTH-1:0]     o_count,
   output logic                 o_ovf
);

   localparam logic [1:0] OP_ADD   = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_RDCLR = 2'd3;

   localparam logic [0:0] ST_SWEEP = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [ABIT-1:0]      sweepIdx_q, sweepIdx_d;

   logic                 s1Valid_q;
   logic [1:0]           s1Op_q;
   logic [ABIT-1:0]      s1Index_q;
   logic [INC_WIDTH-1:0] s1Inc_q;

   logic                 s2Valid_q;
   logic [1:0]           s2Op_q;
   logic [ABIT-1:0]      s2Index_q;
   logic [INC_WIDTH-1:0] s2Inc_q;

   logic                 s3Valid_q;
   logic [1:0]           s3Op_q;
   logic [ABIT-1:0]      s3Index_q;
   logic [INC_WIDTH-1:0] s3Inc_q;
   logic [WIDTH-1:0]     s3Old_q;

   logic                 wb1Valid_q;
   logic [ABIT-1:0]      wb1Index_q;
   logic [WIDTH-1:0]     wb1Data_q;
   logic                 wb2Valid_q;
   logic [ABIT-1:0]      wb2Index_q;
   logic [WIDTH-1:0]     wb2Data_q;

   logic                 oValid_q;
   logic [ABIT-1:0]      oIndex_q;
   logic [WIDTH-1:0]     oCount_q;
   logic                 oOvf_q;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [WIDTH-1:0]     ramQ_q;
   logic                 memWe;
   logic [ABIT-1:0]      memWaddr;
   logic [WIDTH-1:0]     memWdata;

   logic                 accept;
   logic [WIDTH-1:0]     fwdOld;
   logic [WIDTH-1:0]     incExt;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     s3New;
   logic [WIDTH-1:0]     s3Count;
   logic                 s3Ovf;
   logic                 s3Writes;

   assign accept  = i_valid && (state_q == ST_RUN);
   assign o_ready = (state_q == ST_RUN);
   assign o_valid = oValid_q;
   assign o_index = oIndex_q;
   assign o_count = oCount_q;
   assign o_ovf   = oOvf_q;

   always_comb begin
      state_d    = state_q;
      sweepIdx_d = sweepIdx_q;
      if (state_q == ST_SWEEP) begin
         sweepIdx_d = sweepIdx_q + 1'b1;
         if (sweepIdx_q == ABIT'(DEPTH - 1)) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_SWEEP;
         sweepIdx_q <= '0;
      end else begin
         state_q    <= state_d;
         sweepIdx_q <= sweepIdx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Op_q    <= OP_ADD;
         s1Index_q <= '0;
         s1Inc_q   <= '0;
         s2Valid_q <= 1'b0;
         s2Op_q    <= OP_ADD;
         s2Index_q <= '0;
         s2Inc_q   <= '0;
         s3Valid_q <= 1'b0;
         s3Op_q    <= OP_ADD;
         s3Index_q <= '0;
         s3Inc_q   <= '0;
         s3Old_q   <= '0;
      end else begin
         s1Valid_q <= accept;
         s1Op_q    <= i_op;
         s1Index_q <= i_index;
         s1Inc_q   <= i_inc;
         s2Valid_q <= s1Valid_q;
         s2Op_q    <= s1Op_q;
         s2Index_q <= s1Index_q;
         s2Inc_q   <= s1Inc_q;
         s3Valid_q <= s2Valid_q;
         s3Op_q    <= s2Op_q;
         s3Index_q <= s2Index_q;
         s3Inc_q   <= s2Inc_q;
         s3Old_q   <= fwdOld;
      end
   end

   // RAM read-during-write returns the old word; the forwarding below hides that.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[memWaddr] <= memWdata;
      end
      ramQ_q <= mem[s1Index_q];
   end

   // Youngest pending write to the same counter wins over the RAM word.
   always_comb begin
      fwdOld = ramQ_q;
      if (s3Writes && (s3Index_q == s2Index_q)) begin
         fwdOld = s3New;
      end else if (wb1Valid_q && (wb1Index_q == s2Index_q)) begin
         fwdOld = wb1Data_q;
      end else if (wb2Valid_q && (wb2Index_q == s2Index_q)) begin
         fwdOld = wb2Data_q;
      end
   end

   always_comb begin
      incExt                  = '0;
      incExt[INC_WIDTH-1:0]   = s3Inc_q;
      sum                     = {1'b0, s3Old_q} + {1'b0, incExt};
      s3New                   = s3Old_q;
      s3Count                 = s3Old_q;
      s3Ovf                   = 1'b0;
      s3Writes                = 1'b0;
      case (s3Op_q)
         OP_ADD: begin
            s3Ovf    = sum[WIDTH];
            s3New    = (sum[WIDTH] && (SATURATE != 0)) ? '1 : sum[WIDTH-1:0];
            s3Count  = s3New;
            s3Writes = s3Valid_q;
         end
         OP_SET: begin
            s3New    = incExt;
            s3Count  = incExt;
            s3Writes = s3Valid_q;
         end
         OP_RDCLR: begin
            s3New    = '0;
            s3Writes = s3Valid_q;
         end
         default: begin
            s3Writes = 1'b0;
         end
      endcase
   end

   always_comb begin
      memWe    = 1'b0;
      memWaddr = s3Index_q;
      memWdata = s3New;
      if (!rst) begin
         if (state_q == ST_SWEEP) begin
            memWe    = 1'b1;
            memWaddr = sweepIdx_q;
            memWdata = '0;
         end else if (s3Writes) begin
            memWe = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb1Valid_q <= 1'b0;
         wb1Index_q <= '0;
         wb1Data_q  <= '0;
         wb2Valid_q <= 1'b0;
         wb2Index_q <= '0;
         wb2Data_q  <= '0;
      end else begin
         wb1Valid_q <= s3Writes;
         wb1Index_q <= s3Index_q;
         wb1Data_q  <= s3New;
         wb2Valid_q <= wb1Valid_q;
         wb2Index_q <= wb1Index_q;
         wb2Data_q  <= wb1Data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oValid_q <= 1'b0;
         oIndex_q <= '0;
         oCount_q <= '0;
         oOvf_q   <= 1'b0;
      end else begin
         oValid_q <= s3Valid_q;
         if (s3Valid_q) begin
            oIndex_q <= s3Index_q;
            oCount_q <= s3Count;
            oOvf_q   <= s3Ovf;
         end
      end
   end

endmodule

// File: tb/tb_count_accum.sv
// Scoreboard bench for count_accum: one saturating and one wrapping instance share stimulus,
// expectations come from a plain per-counter array model.
module tb_count_accum;

   localparam int     DEPTH     = 16;
   localparam int     WIDTH     = 8;
   localparam int     INC_WIDTH = 8;
   localparam int     ABIT      = $clog2(DEPTH);
   localparam longint MAXV      = (64'd1 << WIDTH) - 1;

   typedef struct {
      int     idx;
      longint cnt;
      bit     ovf;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 iValid = 1'b0;
   logic [1:0]           iOp = 2'd0;
   logic [ABIT-1:0]      iIndex = '0;
   logic [INC_WIDTH-1:0] iInc = '0;

   logic                 oReadySat, oValidSat, oOvfSat;
   logic [ABIT-1:0]      oIndexSat;
   logic [WIDTH-1:0]     oCountSat;
   logic                 oReadyWrap, oValidWrap, oOvfWrap;
   logic [ABIT-1:0]      oIndexWrap;
   logic [WIDTH-1:0]     oCountWrap;

   exp_t   qSat[$];
   exp_t   qWrap[$];
   longint modelSat[DEPTH];
   longint modelWrap[DEPTH];
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   count_accum #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INC_WIDTH(INC_WIDTH), .SATURATE(1)) dutSat (
      .clk(clk), .rst(rst), .i_valid(iValid), .i_op(iOp), .i_index(iIndex), .i_inc(iInc),
      .o_ready(oReadySat), .o_valid(oValidSat), .o_index(oIndexSat), .o_count(oCountSat),
      .o_ovf(oOvfSat)
   );

   count_accum #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INC_WIDTH(INC_WIDTH), .SATURATE(0)) dutWrap (
      .clk(clk), .rst(rst), .i_valid(iValid), .i_op(iOp), .i_index(iIndex), .i_inc(iInc),
      .o_ready(oReadyWrap), .o_valid(oValidWrap), .o_index(oIndexWrap), .o_count(oCountWrap),
      .o_ovf(oOvfWrap)
   );

   // Sequential meaning of each op on a plain array of counters.
   task automatic modelStep(input bit sat, input int op, input int idx, input longint inc,
                            output exp_t e);
      longint oldv, sum, newv;
      oldv  = sat ? modelSat[idx] : modelWrap[idx];
      newv  = oldv;
      e.idx = idx;
      e.cnt = oldv;
      e.ovf = 1'b0;
      case (op)
         0: begin
            sum   = oldv + inc;
            e.ovf = (sum > MAXV);
            newv  = e.ovf ? (sat ? MAXV : sum - (MAXV + 1)) : sum;
            e.cnt = newv;
         end
         1: begin
            newv  = inc;
            e.cnt = inc;
         end
         3: newv = 0;
         default: ;
      endcase
      if (sat) modelSat[idx] = newv;
      else     modelWrap[idx] = newv;
   endtask

   task automatic checkOutput(input string tag, input exp_t e, input int idx, input longint cnt,
                              input bit ovf);
      checks++;
      if (idx != e.idx || cnt != e.cnt || ovf != e.ovf) begin
         errors++;
         $display("[TB] FAIL %s: got idx=%0d count=%0d ovf=%0d, expected idx=%0d count=%0d ovf=%0d",
                  tag, idx, cnt, ovf, e.idx, e.cnt, e.ovf);
      end
   endtask

   // Called at a falling edge; the op is accepted on the next rising edge if ready is high.
   task automatic applyStimulus(input int op, input int idx, input int inc);
      exp_t e;
      iValid = 1'b1;
      iOp    = 2'(op);
      iIndex = ABIT'(idx);
      iInc   = INC_WIDTH'(inc);
      if (oReadySat) begin
         modelStep(1'b1, op, idx, longint'(inc), e);
         qSat.push_back(e);
         modelStep(1'b0, op, idx, longint'(inc), e);
         qWrap.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      iValid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic resetSequence();
      int edges;
      rst    = 1'b1;
      iValid = 1'b0;
      qSat.delete();
      qWrap.delete();
      for (int i = 0; i < DEPTH; i++) begin
         modelSat[i]  = 0;
         modelWrap[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (oReadySat || oValidSat || oIndexSat != 0 || oCountSat != 0 || oOvfSat) begin
         errors++;
         $display("[TB] FAIL reset_sat: got ready=%0d valid=%0d idx=%0d count=%0d ovf=%0d, expected all 0",
                  oReadySat, oValidSat, oIndexSat, oCountSat, oOvfSat);
      end
      checks++;
      if (oReadyWrap || oValidWrap || oIndexWrap != 0 || oCountWrap != 0 || oOvfWrap) begin
         errors++;
         $display("[TB] FAIL reset_wrap: got ready=%0d valid=%0d idx=%0d count=%0d ovf=%0d, expected all 0",
                  oReadyWrap, oValidWrap, oIndexWrap, oCountWrap, oOvfWrap);
      end
      @(negedge clk);
      rst   = 1'b0;
      edges = 0;
      while (edges < 3 * DEPTH) begin
         @(posedge clk);
         edges++;
         #1;
         if (oReadySat) break;
         iValid = 1'b1;
         iOp    = 2'($urandom_range(0, 3));
         iIndex = ABIT'($urandom_range(0, DEPTH - 1));
         iInc   = INC_WIDTH'($urandom_range(0, 255));
      end
      iValid = 1'b0;
      checks++;
      if (edges != DEPTH || !oReadySat || !oReadyWrap) begin
         errors++;
         $display("[TB] FAIL ready_rise: got ready after %0d edges (sat=%0d wrap=%0d), expected after %0d edges",
                  edges, oReadySat, oReadyWrap, DEPTH);
      end
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (oValidSat) begin
            if (qSat.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sat_unexpected: got o_valid=1 idx=%0d count=%0d, expected o_valid=0",
                        oIndexSat, oCountSat);
            end else begin
               e = qSat.pop_front();
               checkOutput("sat_result", e, int'(oIndexSat), longint'(oCountSat), oOvfSat);
            end
         end
         if (oValidWrap) begin
            if (qWrap.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL wrap_unexpected: got o_valid=1 idx=%0d count=%0d, expected o_valid=0",
                        oIndexWrap, oCountWrap);
            end else begin
               e = qWrap.pop_front();
               checkOutput("wrap_result", e, int'(oIndexWrap), longint'(oCountWrap), oOvfWrap);
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      resetSequence();

      repeat (5) applyStimulus(0, 5, 1);
      applyStimulus(2, 5, 0);

      applyStimulus(0, 7, 2);
      applyStimulus(0, 9, 1);
      applyStimulus(0, 7, 3);
      applyStimulus(1, 7, 10);
      applyStimulus(0, 7, 1);

      applyStimulus(1, 3, 250);
      applyStimulus(0, 3, 10);

      applyStimulus(1, 4, 77);
      applyStimulus(3, 4, 0);
      applyStimulus(0, 4, 1);
      idle(4);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)),
                            int'($urandom_range(0, 255)));
      end
      idle(5);

      for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, int'($urandom_range(1, 255)));
      applyStimulus(0, 1, 5);
      applyStimulus(0, 2, 6);
      applyStimulus(0, 3, 7);
      resetSequence();

      for (int i = 0; i < DEPTH; i++) applyStimulus(2, i, 0);
      idle(3);

      for (int c = 0; c < 50 && (qSat.size() != 0 || qWrap.size() != 0); c++) @(negedge clk);
      if (qSat.size() != 0 || qWrap.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d/%0d results still pending, expected 0",
                  qSat.size(), qWrap.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
